// File: rtl/seg_scan_mux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg_scan_mux: time-multiplexed common-anode seven-segment scanner with
// blanking gap, per-digit enable/blink masks and a frame-start strobe.
// Revision: 1.0
// ---------------------------------------------------------------------------
module seg_scan_mux #(
  parameter int         NUM_DIGITS     = 6,
  parameter int         DWELL_CYCLES   = 50000,
  parameter int         BLANK_CYCLES   = 16,
  parameter int         BLINK_FRAMES   = 64,
  parameter bit         SEL_ACTIVE_LOW = 1'b1,
  parameter logic [7:0] BLANK_PATTERN  = 8'hFF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [8*NUM_DIGITS-1:0] seg_data_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [NUM_DIGITS-1:0]   seg_sel,
  output logic [7:0]              seg_data,
  output logic                    frame_start
);

  localparam int c_max_cyc = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int c_cnt_w   = (c_max_cyc > 1) ? $clog2(c_max_cyc) : 1;
  localparam int c_idx_w   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int c_fcnt_w  = $clog2(BLINK_FRAMES + 1);

  localparam logic [0:0] c_st_blank = 1'b0;
  localparam logic [0:0] c_st_drive = 1'b1;
  localparam logic [0:0] c_st_init  = (BLANK_CYCLES == 0) ? c_st_drive : c_st_blank;

  localparam logic [NUM_DIGITS-1:0] c_sel_off = SEL_ACTIVE_LOW ? {NUM_DIGITS{1'b1}}
                                                               : {NUM_DIGITS{1'b0}};

  logic [0:0]            r_state;
  logic [c_cnt_w-1:0]    r_cnt;
  logic [c_idx_w-1:0]    r_idx;
  logic [c_fcnt_w-1:0]   r_fcnt;
  logic                  r_blink_off;

  logic [NUM_DIGITS-1:0] w_sel_on;
  logic [7:0]            w_digit;
  logic                  w_en_sel;
  logic                  w_mask_sel;
  logic                  w_toggle;
  logic                  w_blink_eff;
  logic                  w_vis;
  logic                  w_last;

  always_comb begin
    w_sel_on   = c_sel_off;
    w_digit    = BLANK_PATTERN;
    w_en_sel   = 1'b0;
    w_mask_sel = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == c_idx_w'(i)) begin
        w_sel_on[i] = ~c_sel_off[i];
        w_digit     = seg_data_in[8*i +: 8];
        w_en_sel    = digit_en[i];
        w_mask_sel  = blink_mask[i];
      end
    end
  end

  // r_fcnt holds frame starts since the last toggle; once it has reached
  // BLINK_FRAMES the next frame start flips the phase and applies it to that frame.
  assign w_toggle    = (r_idx == '0) && (r_fcnt == c_fcnt_w'(BLINK_FRAMES));
  assign w_blink_eff = r_blink_off ^ w_toggle;
  assign w_vis       = w_en_sel & ~(w_blink_eff & w_mask_sel);
  assign w_last      = (r_idx == c_idx_w'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= c_st_init;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_fcnt      <= '0;
      r_blink_off <= 1'b0;
      seg_sel     <= c_sel_off;
      seg_data    <= BLANK_PATTERN;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (r_state == c_st_blank) begin
        seg_sel  <= c_sel_off;
        seg_data <= BLANK_PATTERN;
        if (r_cnt == c_cnt_w'(BLANK_CYCLES - 1)) begin
          r_state <= c_st_drive;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + c_cnt_w'(1);
        end
      end else begin
        // Pattern, enable and blink are captured once on slot entry and held.
        if (r_cnt == '0) begin
          seg_sel  <= w_vis ? w_sel_on : c_sel_off;
          seg_data <= w_vis ? w_digit : BLANK_PATTERN;
          if (r_idx == '0) begin
            frame_start <= 1'b1;
            if (w_toggle) begin
              r_blink_off <= ~r_blink_off;
              r_fcnt      <= c_fcnt_w'(1);
            end else begin
              r_fcnt <= r_fcnt + c_fcnt_w'(1);
            end
          end
        end
        if (r_cnt == c_cnt_w'(DWELL_CYCLES - 1)) begin
          r_cnt   <= '0;
          r_idx   <= w_last ? '0 : r_idx + c_idx_w'(1);
          r_state <= (BLANK_CYCLES == 0) ? c_st_drive : c_st_blank;
        end else begin
          r_cnt <= r_cnt + c_cnt_w'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_mux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_seg_scan_mux: directed self-checking bench for seg_scan_mux.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_seg_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] data = 24'hC0_F9_A4;
  logic [2:0]  en_a = 3'b111;
  logic [2:0]  mask_a = 3'b000;
  logic [2:0]  en_all = 3'b111;
  logic [2:0]  mask_none = 3'b000;
  logic        one_en = 1'b1;
  logic        one_mask = 1'b1;

  logic [2:0]  sel_a, sel_z;
  logic [7:0]  dat_a, dat_z, dat_o;
  logic        fs_a, fs_z, fs_o;
  logic        sel_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seg_scan_mux #(.NUM_DIGITS(3), .DWELL_CYCLES(4), .BLANK_CYCLES(2), .BLINK_FRAMES(2),
                 .SEL_ACTIVE_LOW(1'b1), .BLANK_PATTERN(8'hFF)) u_a (
    .clk(clk), .rst_n(rst_n), .seg_data_in(data), .digit_en(en_a),
    .blink_mask(mask_a), .seg_sel(sel_a), .seg_data(dat_a), .frame_start(fs_a));

  seg_scan_mux #(.NUM_DIGITS(3), .DWELL_CYCLES(4), .BLANK_CYCLES(0), .BLINK_FRAMES(2),
                 .SEL_ACTIVE_LOW(1'b1), .BLANK_PATTERN(8'hFF)) u_z (
    .clk(clk), .rst_n(rst_n), .seg_data_in(data), .digit_en(en_all),
    .blink_mask(mask_none), .seg_sel(sel_z), .seg_data(dat_z), .frame_start(fs_z));

  seg_scan_mux #(.NUM_DIGITS(1), .DWELL_CYCLES(3), .BLANK_CYCLES(1), .BLINK_FRAMES(1),
                 .SEL_ACTIVE_LOW(1'b1), .BLANK_PATTERN(8'hFF)) u_one (
    .clk(clk), .rst_n(rst_n), .seg_data_in(data[7:0]), .digit_en(one_en),
    .blink_mask(one_mask), .seg_sel(sel_o), .seg_data(dat_o), .frame_start(fs_o));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic skip(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs at cycle c derived from slot/frame arithmetic.
  function automatic void model(input int c, input int nd, input int d, input int b,
                                input int bf, input logic [7:0] en, input logic [7:0] mk,
                                input logic [63:0] dv, output logic [31:0] e_sel,
                                output logic [31:0] e_dat, output logic [31:0] e_fs);
    int per = b + d;
    int s = c % (nd * per);
    int slot = s / per;
    int p = s % per;
    int f = c / (nd * per);
    bit bo = ((f / bf) % 2) == 1;
    logic [31:0] all_off = (32'd1 << nd) - 32'd1;
    e_fs = (slot == 0 && p == b) ? 32'd1 : 32'd0;
    if (p < b || !en[slot] || (bo && mk[slot])) begin
      e_sel = all_off;
      e_dat = 32'hFF;
    end else begin
      e_sel = all_off & ~(32'd1 << slot);
      e_dat = 32'(dv >> (8 * slot)) & 32'hFF;
    end
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic run(input int c0, input int c1, input bit all);
    logic [31:0] es, ed, ef;
    for (int c = c0; c <= c1; c++) begin
      tick();
      model(c, 3, 4, 2, 2, {5'b0, en_a}, {5'b0, mask_a}, {40'b0, data}, es, ed, ef);
      chk($sformatf("a_sel c%0d", c), {29'b0, sel_a}, es);
      chk($sformatf("a_dat c%0d", c), {24'b0, dat_a}, ed);
      chk($sformatf("a_fs c%0d", c), {31'b0, fs_a}, ef);
      if (all) begin
        model(c, 3, 4, 0, 2, 8'h07, 8'h00, {40'b0, data}, es, ed, ef);
        chk($sformatf("z_sel c%0d", c), {29'b0, sel_z}, es);
        chk($sformatf("z_dat c%0d", c), {24'b0, dat_z}, ed);
        chk($sformatf("z_fs c%0d", c), {31'b0, fs_z}, ef);
        model(c, 1, 3, 1, 1, 8'h01, 8'h01, {40'b0, data}, es, ed, ef);
        chk($sformatf("one_sel c%0d", c), {31'b0, sel_o}, es);
        chk($sformatf("one_dat c%0d", c), {24'b0, dat_o}, ed);
        chk($sformatf("one_fs c%0d", c), {31'b0, fs_o}, ef);
      end
    end
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_a_sel", {29'b0, sel_a}, 32'h7);
    chk("rst_a_dat", {24'b0, dat_a}, 32'hFF);
    chk("rst_a_fs", {31'b0, fs_a}, 32'h0);
    chk("rst_z_sel", {29'b0, sel_z}, 32'h7);
    chk("rst_one_fs", {31'b0, fs_o}, 32'h0);
    rst_n = 1'b1;

    // Basic scan, zero blanking and single-digit blink, two frames
    run(0, 39, 1'b1);

    // Enable mask: digit 1 blanked for its whole slot, period unchanged
    en_a = 3'b101;
    do_reset();
    run(0, 35, 1'b0);

    // Blink on digit 2 over five frames
    en_a = 3'b111;
    mask_a = 3'b100;
    do_reset();
    run(0, 89, 1'b0);

    // Mid-slot changes during digit 1's drive
    mask_a = 3'b000;
    do_reset();
    run(0, 9, 1'b0);
    data = 24'hC0_88_A4;
    en_a = 3'b101;
    tick();
    chk("mid_sel c10", {29'b0, sel_a}, 32'h5);
    chk("mid_dat c10", {24'b0, dat_a}, 32'hF9);
    tick();
    chk("mid_sel c11", {29'b0, sel_a}, 32'h5);
    chk("mid_dat c11", {24'b0, dat_a}, 32'hF9);
    skip(14);
    tick();
    chk("mid_sel c26", {29'b0, sel_a}, 32'h7);
    chk("mid_dat c26", {24'b0, dat_a}, 32'hFF);
    tick();
    chk("mid_sel c27", {29'b0, sel_a}, 32'h7);
    en_a = 3'b111;
    skip(16);
    tick();
    chk("mid_sel c44", {29'b0, sel_a}, 32'h5);
    chk("mid_dat c44", {24'b0, dat_a}, 32'h88);

    // Reset during digit 2's drive while blink phase is off
    data = 24'hC0_F9_A4;
    mask_a = 3'b100;
    do_reset();
    run(0, 50, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("mrst_sel", {29'b0, sel_a}, 32'h7);
    chk("mrst_dat", {24'b0, dat_a}, 32'hFF);
    chk("mrst_fs", {31'b0, fs_a}, 32'h0);
    rst_n = 1'b1;
    run(0, 19, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
